mcpu_core_tlb_responder: RTL

//  Responder side of the core's data-TLB lookup interface. It answers lookups from the DTLB

---
 rtl/mcpu_core_tlb_responder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mcpu_core_tlb_responder.sv
// mcpu_core_tlb_responder
//   Responder side of the core's data-TLB lookup interface. A small fully
//   associative TLB answers lookups in one cycle. On a miss it runs a two-level
//   page-table walk over a single-outstanding read port, fills an entry
//   round-robin and posts the result.
//
// Ports
//   clkrst_core_clk   core clock
//   clkrst_core_rst   core reset, asynchronous assert, active-high
//   i_tlb_addr        lookup VPN (vaddr[31:12])
//   i_tlb_re          lookup request, sampled only while o_tlb_ready=1
//   o_tlb_phys_addr   result PPN (paddr[31:12])
//   o_tlb_flags       result flags {exec,user,writable,present}, 0 = fault
//   o_tlb_ready       idle; outputs hold the latest result
//   i_paging_en       0 = identity translation, TLB untouched
//   i_ptbr            page-directory base (paddr[31:12])
//   i_tlb_inval       invalidate all entries
//   o_pt_mem_addr     walk read word address (paddr[31:2])
//   o_pt_mem_re       walk read request, held until i_pt_mem_rvalid
//   i_pt_mem_rdata    walk read data
//   i_pt_mem_rvalid   read data valid, completes the request
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready; hits and identity lookups complete here
// WALK_PD  | reading the page-directory entry
// WALK_PT  | reading the page-table entry, then post and maybe fill

module mcpu_core_tlb_responder #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst,
    input  logic [19:0] i_tlb_addr,
    input  logic        i_tlb_re,
    output logic [19:0] o_tlb_phys_addr,
    output logic [3:0]  o_tlb_flags,
    output logic        o_tlb_ready,
    input  logic        i_paging_en,
    input  logic [19:0] i_ptbr,
    input  logic        i_tlb_inval,
    output logic [29:0] o_pt_mem_addr,
    output logic        o_pt_mem_re,
    input  logic [31:0] i_pt_mem_rdata,
    input  logic        i_pt_mem_rvalid
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WALK_PD = 2'd1;
    localparam logic [1:0] S_WALK_PT = 2'd2;

    logic [1:0]         r_state;
    logic [19:0]        r_vpn;
    logic               r_inval_pend;
    logic [19:0]        r_phys;
    logic [3:0]         r_flags;
    logic               r_ready;
    logic               r_mem_re;
    logic [29:0]        r_mem_addr;

    logic [ENTRIES-1:0] r_valid;
    logic [IDX_W-1:0]   r_ptr;
    logic [19:0]        r_tag       [ENTRIES];
    logic [19:0]        r_ent_ppn   [ENTRIES];
    logic [3:0]         r_ent_flags [ENTRIES];

    logic               w_accept;
    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_miss_accept;
    logic               w_pt_done;
    logic               w_fill;
    logic               w_unused_rdata;

    // PDE/PTE bits [11:4] carry nothing this responder needs.
    assign w_unused_rdata = &{1'b0, i_pt_mem_rdata[11:4]};

    assign w_accept = i_tlb_re & r_ready;

    // At most one entry can match: fills only follow a miss on that VPN.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_tag[i] == i_tlb_addr)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    assign w_miss_accept = w_accept & i_paging_en & ~w_hit & (r_state == S_IDLE);
    assign w_pt_done     = (r_state == S_WALK_PT) & i_pt_mem_rvalid;
    // An invalidate seen at any point of the walk, including this very cycle,
    // makes the walked translation stale, so it is returned but not cached.
    assign w_fill        = w_pt_done & i_pt_mem_rdata[0] & ~r_inval_pend & ~i_tlb_inval;

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            r_state      <= S_IDLE;
            r_vpn        <= '0;
            r_inval_pend <= 1'b0;
            r_phys       <= '0;
            r_flags      <= '0;
            r_ready      <= 1'b1;
            r_mem_re     <= 1'b0;
            r_mem_addr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // An invalidate coinciding with a miss still belongs to that walk.
                    r_inval_pend <= i_tlb_inval & w_miss_accept;
                    if (w_accept) begin
                        if (!i_paging_en) begin
                            r_phys  <= i_tlb_addr;
                            r_flags <= 4'hF;
                        end else if (w_hit) begin
                            r_phys  <= r_ent_ppn[w_hit_idx];
                            r_flags <= r_ent_flags[w_hit_idx];
                        end else begin
                            r_vpn      <= i_tlb_addr;
                            r_mem_addr <= {i_ptbr, i_tlb_addr[19:10]};
                            r_mem_re   <= 1'b1;
                            r_ready    <= 1'b0;
                            r_state    <= S_WALK_PD;
                        end
                    end
                end
                S_WALK_PD: begin
                    r_inval_pend <= r_inval_pend | i_tlb_inval;
                    if (i_pt_mem_rvalid) begin
                        if (!i_pt_mem_rdata[0]) begin
                            r_phys   <= '0;
                            r_flags  <= '0;
                            r_ready  <= 1'b1;
                            r_mem_re <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            // The PDE frame is held in the address register itself.
                            r_mem_addr <= {i_pt_mem_rdata[31:12], r_vpn[9:0]};
                            r_state    <= S_WALK_PT;
                        end
                    end
                end
                S_WALK_PT: begin
                    r_inval_pend <= r_inval_pend | i_tlb_inval;
                    if (i_pt_mem_rvalid) begin
                        r_phys   <= i_pt_mem_rdata[31:12];
                        r_flags  <= i_pt_mem_rdata[3:0];
                        r_ready  <= 1'b1;
                        r_mem_re <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_ready  <= 1'b1;
                    r_mem_re <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            r_valid <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_fill) begin
                r_ptr <= (r_ptr == IDX_W'(ENTRIES - 1)) ? '0 : r_ptr + 1'b1;
            end
            if (i_tlb_inval) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[r_ptr] <= 1'b1;
            end
        end
    end

    // Entry payload needs no reset; the valid bits gate it.
    always_ff @(posedge clkrst_core_clk) begin
        if (w_fill) begin
            r_tag[r_ptr]       <= r_vpn;
            r_ent_ppn[r_ptr]   <= i_pt_mem_rdata[31:12];
            r_ent_flags[r_ptr] <= i_pt_mem_rdata[3:0];
        end
    end

    assign o_tlb_phys_addr = r_phys;
    assign o_tlb_flags     = r_flags;
    assign o_tlb_ready     = r_ready;
    assign o_pt_mem_addr   = r_mem_addr;
    assign o_pt_mem_re     = r_mem_re;

endmodule
